// File: rtl/decode_ctrl_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the decode controller.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_ctrl_if;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        id_valid;
    logic        ex_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [2:0]  id_encoding;
    logic        id_illegal;
    logic        id_stall;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        flush;

    modport slave (
        input  if_valid, if_instruction, if_pc, ex_ready, ex_mem_read, ex_rd, flush,
        output if_ready, id_valid, id_instruction, id_pc, id_encoding, id_illegal, id_stall
    );

    modport master (
        output if_valid, if_instruction, if_pc, ex_ready, ex_mem_read, ex_rd, flush,
        input  if_ready, id_valid, id_instruction, id_pc, id_encoding, id_illegal, id_stall
    );
endinterface

// File: rtl/decode_ctrl.sv
// RV32I decode-stage controller: 2-entry skid buffer, opcode-to-immediate-encoding
// classification, load-use bubble insertion and redirect flush.
module decode_ctrl #(
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input logic         clk,
    input logic         reset_n,
    decode_ctrl_if.slave bus
);

    typedef enum logic [0:0] {StRun, StBubble} state_e;

    localparam logic [2:0] EncR = 3'd0;
    localparam logic [2:0] EncI = 3'd1;
    localparam logic [2:0] EncS = 3'd2;
    localparam logic [2:0] EncB = 3'd3;
    localparam logic [2:0] EncU = 3'd4;
    localparam logic [2:0] EncJ = 3'd5;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        main_valid_q, main_valid_d;
    logic [31:0] main_instr_q, main_instr_d;
    logic [31:0] main_pc_q, main_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic [2:0]  enc;
    logic        illegal;
    logic        use_rs1;
    logic        use_rs2;
    logic        hazard;
    logic        if_xfer;
    logic        ex_xfer;

    always_comb begin
        enc     = EncI;
        illegal = 1'b0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (main_instr_q[6:0])
            7'b0110011: begin enc = EncR; use_rs2 = 1'b1; end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: enc = EncI;
            7'b0100011: begin enc = EncS; use_rs2 = 1'b1; end
            7'b1100011: begin enc = EncB; use_rs2 = 1'b1; end
            7'b0110111, 7'b0010111: begin enc = EncU; use_rs1 = 1'b0; end
            7'b1101111: begin enc = EncJ; use_rs1 = 1'b0; end
            default: illegal = 1'b1;
        endcase
    end

    assign hazard = main_valid_q && (state_q == StRun) && bus.ex_mem_read &&
                    (bus.ex_rd != 5'd0) &&
                    ((use_rs1 && (main_instr_q[19:15] == bus.ex_rd)) ||
                     (use_rs2 && (main_instr_q[24:20] == bus.ex_rd)));

    // if_ready depends on state only so fetch never sees a combinational path from execute.
    assign bus.if_ready       = ~skid_valid_q;
    assign bus.id_valid       = main_valid_q && (state_q == StRun) && !hazard && !bus.flush;
    assign bus.id_stall       = hazard || (state_q == StBubble);
    assign bus.id_instruction = main_instr_q;
    assign bus.id_pc          = main_pc_q;
    assign bus.id_encoding    = main_valid_q ? enc : EncR;
    assign bus.id_illegal     = main_valid_q && illegal;

    assign if_xfer = bus.if_valid && !skid_valid_q && !bus.flush;
    assign ex_xfer = bus.id_valid && bus.ex_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            state_d      = StRun;
            cnt_d        = 3'd0;
        end else begin
            if (ex_xfer) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                    skid_valid_d = 1'b0;
                end else if (if_xfer) begin
                    main_valid_d = 1'b1;
                    main_instr_d = bus.if_instruction;
                    main_pc_d    = bus.if_pc;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (if_xfer) begin
                if (!main_valid_q) begin
                    main_valid_d = 1'b1;
                    main_instr_d = bus.if_instruction;
                    main_pc_d    = bus.if_pc;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_instr_d = bus.if_instruction;
                    skid_pc_d    = bus.if_pc;
                end
            end
            case (state_q)
                StRun: begin
                    if (hazard && (LOAD_USE_BUBBLES > 1)) begin
                        state_d = StBubble;
                        cnt_d   = 3'(LOAD_USE_BUBBLES - 1);
                    end
                end
                StBubble: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_d = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRun;
            cnt_q        <= 3'd0;
            main_valid_q <= 1'b0;
            main_instr_q <= 32'd0;
            main_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule
